bounce_scanner: RTL

BOUNCE_SCANNER -- requirements
Module: bounce_scanner

---
 rtl/bounce_pkg.sv | 13 +
 rtl/step_prescaler.sv | 26 ++
 rtl/bounce_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce/wrap position scanner.
package bounce_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    DWELL = 2'd2
  } scan_state_t;

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_WRAP   = 1'b1;

endpackage

// File: rtl/step_prescaler.sv
// Step divider: one tick every presc+1 enabled cycles; count clears when disabled.
module step_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en && (cnt == presc);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/bounce_scanner.sv
// Position scanner between lo and hi: bounces (with optional endpoint dwell) or wraps,
// advancing one step per prescaler tick.
module bounce_scanner #(
  parameter int POS_W   = 3,
  parameter int PRESC_W = 8,
  parameter int DWELL   = 0
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               en,
  input  logic               mode,
  input  logic [POS_W-1:0]   lo,
  input  logic [POS_W-1:0]   hi,
  input  logic [PRESC_W-1:0] presc,
  output logic [POS_W-1:0]   pos,
  output logic               dir,
  output logic               bnd,
  output logic               cfg_err
);
  import bounce_pkg::*;

  // The dwell counter only has to reach DWELL-1.
  localparam int DCNT_W = (DWELL < 2) ? 1 : $clog2(DWELL);
  localparam int DWELL_LAST_I = (DWELL > 0) ? DWELL - 1 : 0;
  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL_LAST_I);
  localparam scan_state_t AFTER_HI = (DWELL > 0) ? bounce_pkg::DWELL : LEFT;
  localparam scan_state_t AFTER_LO = (DWELL > 0) ? bounce_pkg::DWELL : RIGHT;

  logic              tick;
  logic              out_of_range;
  scan_state_t       state, state_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              dir_nxt, bnd_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;

  step_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .arst  (arst),
    .en    (en),
    .presc (presc),
    .tick  (tick)
  );

  assign cfg_err      = (lo >= hi);
  assign out_of_range = (pos < lo) || (pos > hi);

  // Bounds are compared before any increment/decrement, so hi at full scale never overflows.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    dir_nxt   = dir;
    bnd_nxt   = 1'b0;
    dcnt_nxt  = dcnt;
    if (tick && !cfg_err) begin
      if (out_of_range) begin
        pos_nxt   = lo;
        dir_nxt   = 1'b1;
        state_nxt = RIGHT;
        dcnt_nxt  = '0;
      end else if (mode == MODE_WRAP && state != RIGHT) begin
        dir_nxt   = 1'b1;
        state_nxt = RIGHT;
        dcnt_nxt  = '0;
      end else begin
        case (state)
          RIGHT: begin
            if (pos < hi) begin
              pos_nxt = pos + POS_W'(1);
            end else if (mode == MODE_WRAP) begin
              pos_nxt = lo;
              bnd_nxt = 1'b1;
            end else begin
              dir_nxt   = 1'b0;
              bnd_nxt   = 1'b1;
              state_nxt = AFTER_HI;
            end
          end
          LEFT: begin
            if (pos > lo) begin
              pos_nxt = pos - POS_W'(1);
            end else begin
              dir_nxt   = 1'b1;
              bnd_nxt   = 1'b1;
              state_nxt = AFTER_LO;
            end
          end
          bounce_pkg::DWELL: begin
            if (dcnt == DWELL_LAST) begin
              dcnt_nxt  = '0;
              state_nxt = dir ? RIGHT : LEFT;
            end else begin
              dcnt_nxt = dcnt + DCNT_W'(1);
            end
          end
          default: state_nxt = RIGHT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= RIGHT;
      pos   <= '0;
      dir   <= 1'b1;
      bnd   <= 1'b0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      dir   <= dir_nxt;
      bnd   <= bnd_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

endmodule
